// File: rtl/iomem_pkg.sv
// Shared widths, address map constants and FSM encoding for the iomem bus-master engine.
package iomem_pkg;

    localparam int unsigned IOMEM_ADDR_W = 32;
    localparam int unsigned IOMEM_DATA_W = 32;
    localparam int unsigned IOMEM_STRB_W = 4;

    localparam logic [7:0] IOMEM_GPIO_PAGE = 8'h03;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } iomem_init_state_t;

endpackage

// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus master: takes one command, runs one iomem transaction,
// returns one response, with a bounded wait for iomem_ready and transaction statistics.
module iomem_initiator
    import iomem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] TIMEOUT_RDATA  = 32'hDEAD_BEEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [IOMEM_ADDR_W-1:0] cmd_addr,
    input  logic [IOMEM_DATA_W-1:0] cmd_wdata,
    input  logic [IOMEM_STRB_W-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IOMEM_DATA_W-1:0] rsp_rdata,
    output logic                    rsp_timeout,
    output logic                    iomem_valid,
    input  logic                    iomem_ready,
    output logic [IOMEM_STRB_W-1:0] iomem_wstrb,
    output logic [IOMEM_ADDR_W-1:0] iomem_addr,
    output logic [IOMEM_DATA_W-1:0] iomem_wdata,
    input  logic [IOMEM_DATA_W-1:0] iomem_rdata,
    output logic                    busy,
    output logic [15:0]             txn_count,
    output logic [7:0]              timeout_count
);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_REQ  = REQ;
    localparam logic [1:0] S_RSP  = RSP;

    localparam int unsigned TIMER_W = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    logic [1:0]              state_q,         state_d;
    logic                    cmd_ready_q,     cmd_ready_d;
    logic                    rsp_valid_q,     rsp_valid_d;
    logic [IOMEM_DATA_W-1:0] rsp_rdata_q,     rsp_rdata_d;
    logic                    rsp_timeout_q,   rsp_timeout_d;
    logic                    iomem_valid_q,   iomem_valid_d;
    logic [IOMEM_STRB_W-1:0] iomem_wstrb_q,   iomem_wstrb_d;
    logic [IOMEM_ADDR_W-1:0] iomem_addr_q,    iomem_addr_d;
    logic [IOMEM_DATA_W-1:0] iomem_wdata_q,   iomem_wdata_d;
    logic                    busy_q,          busy_d;
    logic [15:0]             txn_count_q,     txn_count_d;
    logic [7:0]              timeout_count_q, timeout_count_d;
    logic [TIMER_W-1:0]      timer_q,         timer_d;

    // Next-state and next-output logic.
    always_comb begin
        state_d         = state_q;
        cmd_ready_d     = cmd_ready_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_rdata_d     = rsp_rdata_q;
        rsp_timeout_d   = rsp_timeout_q;
        iomem_valid_d   = iomem_valid_q;
        iomem_wstrb_d   = iomem_wstrb_q;
        iomem_addr_d    = iomem_addr_q;
        iomem_wdata_d   = iomem_wdata_q;
        busy_d          = busy_q;
        txn_count_d     = txn_count_q;
        timeout_count_d = timeout_count_q;
        timer_d         = timer_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    iomem_addr_d  = cmd_addr;
                    iomem_wdata_d = cmd_wdata;
                    iomem_wstrb_d = cmd_wstrb;
                    iomem_valid_d = 1'b1;
                    cmd_ready_d   = 1'b0;
                    busy_d        = 1'b1;
                    timer_d       = '0;
                    state_d       = S_REQ;
                end
            end
            S_REQ: begin
                // A ready on the limit cycle still counts as a completion.
                if (iomem_ready) begin
                    iomem_valid_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = (iomem_wstrb_q == '0) ? iomem_rdata : '0;
                    rsp_timeout_d = 1'b0;
                    txn_count_d   = txn_count_q + 16'd1;
                    state_d       = S_RSP;
                end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                    iomem_valid_d   = 1'b0;
                    rsp_valid_d     = 1'b1;
                    rsp_rdata_d     = TIMEOUT_RDATA;
                    rsp_timeout_d   = 1'b1;
                    timeout_count_d = (timeout_count_q == 8'hFF) ? timeout_count_q
                                                                 : timeout_count_q + 8'd1;
                    state_d         = S_RSP;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                iomem_valid_d = 1'b0;
                rsp_valid_d   = 1'b0;
                cmd_ready_d   = 1'b1;
                busy_d        = 1'b0;
                state_d       = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cmd_ready_q     <= 1'b1;
            rsp_valid_q     <= 1'b0;
            rsp_rdata_q     <= '0;
            rsp_timeout_q   <= 1'b0;
            iomem_valid_q   <= 1'b0;
            iomem_wstrb_q   <= '0;
            iomem_addr_q    <= '0;
            iomem_wdata_q   <= '0;
            busy_q          <= 1'b0;
            txn_count_q     <= '0;
            timeout_count_q <= '0;
            timer_q         <= '0;
        end else begin
            state_q         <= state_d;
            cmd_ready_q     <= cmd_ready_d;
            rsp_valid_q     <= rsp_valid_d;
            rsp_rdata_q     <= rsp_rdata_d;
            rsp_timeout_q   <= rsp_timeout_d;
            iomem_valid_q   <= iomem_valid_d;
            iomem_wstrb_q   <= iomem_wstrb_d;
            iomem_addr_q    <= iomem_addr_d;
            iomem_wdata_q   <= iomem_wdata_d;
            busy_q          <= busy_d;
            txn_count_q     <= txn_count_d;
            timeout_count_q <= timeout_count_d;
            timer_q         <= timer_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_timeout   = rsp_timeout_q;
    assign iomem_valid   = iomem_valid_q;
    assign iomem_wstrb   = iomem_wstrb_q;
    assign iomem_addr    = iomem_addr_q;
    assign iomem_wdata   = iomem_wdata_q;
    assign busy          = busy_q;
    assign txn_count     = txn_count_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// Scoreboard bench for iomem_initiator against a GPIO-style responder with adjustable ready delay.
module tb_iomem_initiator;

    typedef struct {
        logic [31:0] rdata;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_rdata;
    logic        rsp_timeout;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        busy;
    logic [15:0] txn_count;
    logic [7:0]  timeout_count;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    int   exp_txn = 0;
    int   exp_to = 0;

    // Responder model controls
    bit          resp_en = 1'b1;
    int          resp_delay = 1;
    logic        force_rdy = 1'b0;
    logic        m_ready;
    logic [31:0] m_rdata;
    logic [15:0] gpio;
    int          vcnt;
    int          vcyc = 0;

    always #5 clk = ~clk;

    iomem_initiator #(.TIMEOUT_CYCLES(8), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
        .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
        .busy(busy), .txn_count(txn_count), .timeout_count(timeout_count)
    );

    assign iomem_ready = m_ready | force_rdy;
    assign iomem_rdata = m_rdata;

    // GPIO responder: sw=16'hA5A5 in the upper half, gpio register in the lower half.
    always @(posedge clk) begin
        if (reset) begin
            m_ready <= 1'b0;
            m_rdata <= '0;
            gpio    <= 16'h1234;
            vcnt    <= 0;
        end else begin
            m_ready <= 1'b0;
            if (iomem_valid && !m_ready) begin
                if (resp_en && (vcnt + 1 == resp_delay)) begin
                    m_ready <= 1'b1;
                    m_rdata <= {16'hA5A5, gpio};
                    if (iomem_wstrb[0]) gpio[7:0]  <= iomem_wdata[7:0];
                    if (iomem_wstrb[1]) gpio[15:8] <= iomem_wdata[15:8];
                    vcnt <= 0;
                end else begin
                    vcnt <= vcnt + 1;
                end
            end else begin
                vcnt <= 0;
            end
        end
    end

    always @(negedge clk) if (iomem_valid) vcyc <= vcyc + 1;

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output bit ok);
        @(negedge clk);
        cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (cmd_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [31:0] rd, output logic to, output int lat, output bit ok);
        lat = 0; ok = 1'b0; rd = '0; to = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            lat++;
            if (rsp_valid) begin ok = 1'b1; rd = rsp_rdata; to = rsp_timeout; break; end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        total++; if (iomem_valid !== 1'b0) begin bad++; $display("FAIL reset_iomem_valid got=%b want=0", iomem_valid); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (txn_count !== 16'h0 || timeout_count !== 8'h0) begin
            bad++; $display("FAIL reset_counters got=%h/%h want=0/0", txn_count, timeout_count); end
        total++; if (iomem_addr !== 32'h0 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_regs addr=%h rdata=%h want=0/0", iomem_addr, rsp_rdata); end
    endtask

    task automatic test_read();
        logic [31:0] rd; logic to; int lat; bit ok; int v0; exp_t e;
        resp_en = 1'b1; resp_delay = 1;
        sb.push_back('{32'hA5A5_1234, 1'b0});
        exp_txn++;
        v0 = vcyc;
        issue(32'h0300_0000, 32'h0, 4'b0000, ok);
        wait_rsp(rd, to, lat, ok);
        e = sb.pop_front();
        total++; if (!ok || lat != 3) begin bad++; $display("FAIL read_latency got=%0d ok=%0b want=3", lat, ok); end
        total++; if (vcyc - v0 != 2) begin bad++; $display("FAIL read_valid_cycles got=%0d want=2", vcyc - v0); end
        total++; if (rd !== e.rdata) begin bad++; $display("FAIL read_rdata got=%h want=%h", rd, e.rdata); end
        total++; if (to !== e.to) begin bad++; $display("FAIL read_timeout got=%b want=%b", to, e.to); end
        total++; if (txn_count !== 16'(exp_txn)) begin bad++; $display("FAIL read_txn got=%0d want=%0d", txn_count, exp_txn); end
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL read_back_idle cmd_ready=%b rsp_valid=%b want=1/0", cmd_ready, rsp_valid); end
    endtask

    task automatic test_partial_write();
        logic [31:0] rd; logic to; int lat; bit ok; exp_t e;
        sb.push_back('{32'h0, 1'b0});
        exp_txn++;
        issue(32'h0300_0000, 32'h0000_00FF, 4'b0001, ok);
        wait_rsp(rd, to, lat, ok);
        e = sb.pop_front();
        total++; if (!ok || rd !== e.rdata || to !== e.to) begin
            bad++; $display("FAIL write_rsp got=%h/%b ok=%0b want=%h/%b", rd, to, ok, e.rdata, e.to); end
        total++; if (gpio !== 16'h12FF) begin bad++; $display("FAIL write_gpio got=%h want=12ff", gpio); end
        sb.push_back('{32'hA5A5_12FF, 1'b0});
        exp_txn++;
        issue(32'h0300_0000, 32'h0, 4'b0000, ok);
        wait_rsp(rd, to, lat, ok);
        e = sb.pop_front();
        total++; if (!ok || rd !== e.rdata) begin bad++; $display("FAIL write_readback got=%h want=%h", rd, e.rdata); end
        total++; if (txn_count !== 16'(exp_txn)) begin bad++; $display("FAIL write_txn got=%0d want=%0d", txn_count, exp_txn); end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic to; int lat; bit ok; int v0; exp_t e;
        resp_en = 1'b0;
        sb.push_back('{32'hDEAD_BEEF, 1'b1});
        exp_to++;
        v0 = vcyc;
        issue(32'h0300_0004, 32'h0, 4'b0000, ok);
        wait_rsp(rd, to, lat, ok);
        e = sb.pop_front();
        total++; if (!ok || lat != 9) begin bad++; $display("FAIL timeout_latency got=%0d ok=%0b want=9", lat, ok); end
        total++; if (vcyc - v0 != 8) begin bad++; $display("FAIL timeout_valid_cycles got=%0d want=8", vcyc - v0); end
        total++; if (rd !== e.rdata || to !== e.to) begin
            bad++; $display("FAIL timeout_rsp got=%h/%b want=%h/%b", rd, to, e.rdata, e.to); end
        total++; if (timeout_count !== 8'(exp_to)) begin bad++; $display("FAIL timeout_count got=%0d want=%0d", timeout_count, exp_to); end
        repeat (2) @(negedge clk);
        force_rdy = 1'b1;
        @(negedge clk);
        force_rdy = 1'b0;
        @(negedge clk);
        total++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL late_ready busy=%b rsp_valid=%b cmd_ready=%b want=0/0/1", busy, rsp_valid, cmd_ready); end
        total++; if (txn_count !== 16'(exp_txn)) begin bad++; $display("FAIL late_ready_txn got=%0d want=%0d", txn_count, exp_txn); end
    endtask

    task automatic test_boundary();
        logic [31:0] rd; logic to; int lat; bit ok; int v0; exp_t e;
        resp_en = 1'b1; resp_delay = 7;
        sb.push_back('{32'hA5A5_12FF, 1'b0});
        exp_txn++;
        v0 = vcyc;
        issue(32'h0300_0000, 32'h0, 4'b0000, ok);
        wait_rsp(rd, to, lat, ok);
        e = sb.pop_front();
        total++; if (!ok || vcyc - v0 != 8) begin bad++; $display("FAIL boundary_valid_cycles got=%0d want=8", vcyc - v0); end
        total++; if (rd !== e.rdata || to !== e.to) begin
            bad++; $display("FAIL boundary_rsp got=%h/%b want=%h/%b", rd, to, e.rdata, e.to); end
        total++; if (txn_count !== 16'(exp_txn) || timeout_count !== 8'(exp_to)) begin
            bad++; $display("FAIL boundary_counts got=%0d/%0d want=%0d/%0d", txn_count, timeout_count, exp_txn, exp_to); end
        resp_delay = 1;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic to; int lat; bit ok; exp_t e; int errs;
        rsp_ready = 1'b0;
        sb.push_back('{32'hA5A5_12FF, 1'b0});
        exp_txn++;
        issue(32'h0300_0000, 32'h0, 4'b0000, ok);
        wait_rsp(rd, to, lat, ok);
        e = sb.pop_front();
        total++; if (!ok || rd !== e.rdata) begin bad++; $display("FAIL bp_rsp got=%h want=%h", rd, e.rdata); end
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || cmd_ready !== 1'b0 || iomem_valid !== 1'b0) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_hold bad_cycles=%0d want=0", errs); end
        rsp_ready = 1'b1;
        @(negedge clk);
        total++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release rsp_valid=%b busy=%b cmd_ready=%b want=0/0/1", rsp_valid, busy, cmd_ready); end
    endtask

    task automatic test_saturation();
        logic [31:0] rd; logic to; int lat; bit ok; int lost; exp_t e;
        resp_en = 1'b0;
        lost = 0;
        for (int i = 0; i < 255; i++) begin
            sb.push_back('{32'hDEAD_BEEF, 1'b1});
            if (exp_to < 255) exp_to++;
            issue(32'h0300_0008, 32'h0, 4'b0000, ok);
            wait_rsp(rd, to, lat, ok);
            e = sb.pop_front();
            if (!ok || rd !== e.rdata || to !== e.to) lost++;
        end
        total++; if (lost != 0) begin bad++; $display("FAIL sat_rsps bad=%0d want=0", lost); end
        total++; if (timeout_count !== 8'(exp_to)) begin bad++; $display("FAIL sat_count got=%h want=%h", timeout_count, 8'(exp_to)); end
    endtask

    task automatic test_reset_mid_req();
        bit ok; int seen;
        resp_en = 1'b0;
        issue(32'h0300_0000, 32'h0, 4'b0000, ok);
        repeat (2) @(negedge clk);
        total++; if (iomem_valid !== 1'b1) begin bad++; $display("FAIL midreq_precond got=%b want=1", iomem_valid); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_txn = 0; exp_to = 0;
        total++; if (iomem_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++; $display("FAIL midreq_state valid=%b busy=%b cmd_ready=%b want=0/0/1", iomem_valid, busy, cmd_ready); end
        total++; if (txn_count !== 16'(exp_txn) || timeout_count !== 8'(exp_to)) begin
            bad++; $display("FAIL midreq_counters got=%0d/%0d want=0/0", txn_count, timeout_count); end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL midreq_no_rsp got=%0d want=0", seen); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_partial_write();
        test_timeout();
        test_boundary();
        test_backpressure();
        test_saturation();
        test_reset_mid_req();
        total++; if (sb.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", sb.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/iomem_initiator.md
Name: iomem_initiator

Overview:
- Bus-master engine for the PicoSoC iomem interface: drives valid/addr/wdata/wstrb and waits for ready/rdata.
- Lets fabric logic (test sequencers, DMA-like helpers, on-board self-test) reach iomem peripherals such as the GPIO responder at 0x03xx_xxxx without a CPU.
- Accepts one command at a time over a valid/ready port, runs exactly one iomem transaction, returns one response.
- Includes a response timeout and transaction statistics.

Parameters:
TIMEOUT_CYCLES, 255, cycles iomem_valid may stay high without iomem_ready before abort; 0 disables timeout
TIMEOUT_RDATA, 32'hDEAD_BEEF, rsp_rdata value returned on timeout

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command offered
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_addr  input  32  target address
cmd_wdata  input  32  write data
cmd_wstrb  input  4  byte enables; 4'b0000 = read
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  output  32  read data (0 for writes, TIMEOUT_RDATA on timeout)
rsp_timeout  output  1  response is a timeout abort
iomem_valid  output  1  iomem request
iomem_ready  input  1  iomem completion pulse
iomem_wstrb  output  4  iomem byte enables
iomem_addr  output  32  iomem address
iomem_wdata  output  32  iomem write data
iomem_rdata  input  32  iomem read data, valid with iomem_ready
busy  output  1  high in any state other than IDLE
txn_count  output  16  completed (non-timeout) transactions, wrapping
timeout_count  output  8  timeouts, saturating at 8'hFF

Behaviour:
- All outputs are registered.
- Reset (synchronous, active-high) takes priority over all other activity and applies mid-transaction: state IDLE; iomem_valid=0; iomem_addr/wdata/wstrb=0; rsp_valid=0; rsp_rdata=0; rsp_timeout=0; counters=0; cmd_ready=1 from the first cycle after reset.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - cmd_ready=1.
  - On accept in cycle N: latch addr/wdata/wstrb onto iomem_*, set iomem_valid=1 from N+1, clear timer, go to REQ.
- REQ:
  - cmd_ready=0; iomem_valid and iomem_addr/wdata/wstrb are held stable.
  - If iomem_ready=1: iomem_valid=0 next cycle; rsp_rdata = (wstrb==0) ? iomem_rdata : 0; rsp_timeout=0; txn_count+1; go to RSP.
  - Else if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1: iomem_valid=0; rsp_rdata=TIMEOUT_RDATA; rsp_timeout=1; timeout_count+1 (saturating); go to RSP.
  - Else timer+1.
  - iomem_ready in the same cycle as the timeout limit counts as completion; ready wins.
  - Timer width: $clog2(TIMEOUT_CYCLES+1), minimum 1.
- RSP:
  - rsp_valid=1; rsp_rdata and rsp_timeout held stable until rsp_ready.
  - On rsp_ready: rsp_valid=0 next cycle, go to IDLE.
- iomem_valid is low for at least 2 cycles between transactions (RSP + IDLE), which satisfies the responder's "valid && !ready" rule.
- iomem_ready outside REQ is ignored, including a late ready after a timeout.
- Latency with the GPIO responder (ready one cycle after valid) and rsp_ready tied high:
  - N accept; N+1 iomem_valid; N+2 iomem_ready; N+3 rsp_valid.
  - Next command accepted at N+4 at the earliest.
- Timer and counters wrap or saturate exactly as stated; no other arithmetic.

Decomposition:
- Package iomem_pkg holds:
  - IOMEM_ADDR_W=32, IOMEM_DATA_W=32, IOMEM_STRB_W=4
  - IOMEM_GPIO_PAGE=8'h03
  - enum iomem_init_state_t {IDLE, REQ, RSP}
- No sub-module: FSM, timer and counters stay inline.

Test Plan:
- Read: with the GPIO responder model (sw=16'hA5A5, gpio=16'h1234), issue cmd_addr=32'h0300_0000, wstrb=0 -> iomem_valid high N+1..N+2; rsp_rdata=32'hA5A5_1234, rsp_timeout=0, rsp_valid at N+3; txn_count=1.
- Partial write: wstrb=4'b0001, wdata=32'h0000_00FF to 0x0300_0000 -> responder gpio[7:0]=8'hFF, gpio[15:8] unchanged; rsp_rdata=0.
- Timeout: TIMEOUT_CYCLES=8 with a responder that never readies -> iomem_valid high exactly 8 cycles; rsp_rdata=32'hDEAD_BEEF, rsp_timeout=1; timeout_count=1; a late ready 3 cycles later has no effect.
- Boundary and saturation: ready arrives on the 8th valid cycle -> normal completion, no timeout. Separately, 256 timeouts -> timeout_count stays 8'hFF.
- Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, iomem_valid=0 throughout; release -> IDLE one cycle later.
- Reset mid-REQ: assert reset while iomem_valid=1 -> next cycle iomem_valid=0, busy=0, counters=0, cmd_ready=1; no response emitted.
